// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predictor / resolver slice.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - FSM state encodings (ST_INIT/ST_RUN)
//   - pc_to_idx(): word-aligned PC to table index mapping
package branch_predict_resolve_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Drops pc[1:0] and keeps the next idx_w bits; callers narrow the result.
  function automatic logic [63:0] pc_to_idx(input logic [63:0] pc,
                                            input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bht_sat_counter_array.sv
// Direct-mapped array of 2-bit saturating counters.
//   clk      : clock
//   rd_idx   : read index (asynchronous read)
//   rd_data  : counter at rd_idx, pre-update value in a colliding cycle
//   wr_en    : write strobe
//   wr_init  : when set, write WNT instead of a saturating update
//   wr_idx   : write index
//   wr_taken : update direction (1 = increment, 0 = decrement)
module bht_sat_counter_array
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned IDX_W   = 6
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_data,
  input  logic             wr_en,
  input  logic             wr_init,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] mem [ENTRIES];
  logic [1:0] cur;
  logic [1:0] nxt;

  assign rd_data = mem[rd_idx];

  always_comb begin
    cur = mem[wr_idx];
    nxt = cur;
    if (wr_init)
      nxt = WNT;
    else if (wr_taken)
      nxt = (cur == ST) ? ST : cur + 2'd1;
    else
      nxt = (cur == SNT) ? SNT : cur - 2'd1;
  end

  // Storage is intentionally unreset; the top-level sweep initialises it.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= nxt;
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch direction predictor and execute-stage resolver.
//   fetch_valid/fetch_pc     : PC to predict; pred_valid/pred_taken one cycle later
//   ex_valid/ex_pc/ex_pred_taken/ex_branch_result/ex_target : resolved branch
//   redirect_valid/redirect_pc/flush : registered one-cycle mispredict redirect
//   init_busy                : table sweep in progress
//   branch_count/mispredict_count : wrapping statistics
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDX_W       = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            ex_branch_result,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            init_busy,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_ptr;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       rd_data;
  logic             in_run;
  logic             update;
  logic             mispredict;

  assign fetch_idx  = IDX_W'(pc_to_idx(64'(fetch_pc), IDX_W));
  assign ex_idx     = IDX_W'(pc_to_idx(64'(ex_pc), IDX_W));
  assign in_run     = (state == ST_RUN);
  assign init_busy  = (state == ST_INIT);
  assign update     = ex_valid & in_run;
  assign mispredict = ex_valid & (ex_pred_taken != ex_branch_result);
  assign wr_idx     = in_run ? ex_idx : sweep_ptr;
  assign flush      = redirect_valid;

  bht_sat_counter_array #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rd_idx   (fetch_idx),
    .rd_data  (rd_data),
    .wr_en    (init_busy | update),
    .wr_init  (init_busy),
    .wr_idx   (wr_idx),
    .wr_taken (ex_branch_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_ptr <= '0;
    end else if (state == ST_INIT) begin
      sweep_ptr <= sweep_ptr + 1'b1;
      if (sweep_ptr == IDX_W'(BHT_ENTRIES - 1))
        state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= fetch_valid;
      pred_taken <= fetch_valid & in_run & rd_data[1];
    end
  end

  // Redirect is evaluated even during the sweep; only table and stats wait for RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict)
        redirect_pc <= ex_branch_result ? ex_target : ex_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update) begin
      branch_count <= branch_count + 32'd1;
      if (mispredict)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed self-checking bench for branch_predict_resolve.
module tb_branch_predict_resolve;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_branch_result;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        init_busy;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_predict_resolve #(
    .XLEN        (32),
    .BHT_ENTRIES (64),
    .IDX_W       (6)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid      (fetch_valid),
    .fetch_pc         (fetch_pc),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_branch_result (ex_branch_result),
    .ex_target        (ex_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .init_busy        (init_busy),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ex_drive(input logic [31:0] pc, input logic pt, input logic res,
                          input logic [31:0] tgt);
    ex_valid = 1'b1;
    ex_pc = pc;
    ex_pred_taken = pt;
    ex_branch_result = res;
    ex_target = tgt;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_pred_valid"}, 32'(pred_valid), 32'd0);
    chk({tag, "_pred_taken"}, 32'(pred_taken), 32'd0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_init_busy"}, 32'(init_busy), 32'd1);
    chk({tag, "_branch_count"}, branch_count, 32'd0);
    chk({tag, "_mispredict_count"}, mispredict_count, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0;
    fetch_pc = '0;
    ex_valid = 1'b0;
    ex_pc = '0;
    ex_pred_taken = 1'b0;
    ex_branch_result = 1'b0;
    ex_target = '0;
    tick();
    tick();
    reset_vals("rst");
    rst_n = 1'b1;

    // Sweep: busy for exactly 64 edges; a mispredict mid-sweep still redirects.
    for (int i = 1; i <= 64; i++) begin
      if (i == 10) ex_drive(32'h40, 1'b0, 1'b1, 32'h80);
      if (i == 64) begin fetch_valid = 1'b1; fetch_pc = 32'h100; end
      tick();
      if (i == 10) begin
        chk("init_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("init_redirect_pc", redirect_pc, 32'h80);
        chk("init_branch_count", branch_count, 32'd0);
        chk("init_mispredict_count", mispredict_count, 32'd0);
        ex_valid = 1'b0;
      end
      if (i == 11) chk("init_redirect_pulse_end", 32'(redirect_valid), 32'd0);
      if (i == 63) chk("init_busy_63", 32'(init_busy), 32'd1);
      if (i == 64) begin
        chk("init_busy_64", 32'(init_busy), 32'd0);
        chk("init_pred_valid", 32'(pred_valid), 32'd1);
        chk("init_pred_taken", 32'(pred_taken), 32'd0);
      end
    end

    // First RUN-mode fetch of 0x100: counter is WNT.
    tick();
    chk("run_pred_valid", 32'(pred_valid), 32'd1);
    chk("run_pred_wnt", 32'(pred_taken), 32'd0);
    fetch_valid = 1'b0;
    tick();
    chk("pred_valid_drop", 32'(pred_valid), 32'd0);

    // Train 0x100 taken twice: 01 -> 10 -> 11.
    ex_drive(32'h100, 1'b1, 1'b1, 32'h500);
    tick();
    tick();
    ex_valid = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 32'h100;
    tick();
    chk("train_taken", 32'(pred_taken), 32'd1);
    chk("train_branch_count", branch_count, 32'd2);
    chk("train_no_redirect", 32'(redirect_valid), 32'd0);
    fetch_valid = 1'b0;

    // Third taken saturates at 11; one not-taken gives 10 (still taken).
    ex_drive(32'h100, 1'b1, 1'b1, 32'h500);
    tick();
    ex_drive(32'h100, 1'b1, 1'b0, 32'h500);
    ex_pred_taken = 1'b0;
    tick();
    ex_valid = 1'b0;
    fetch_valid = 1'b1;
    tick();
    chk("sat_then_nt_taken", 32'(pred_taken), 32'd1);
    fetch_valid = 1'b0;
    ex_drive(32'h100, 1'b0, 1'b0, 32'h500);
    tick();
    ex_valid = 1'b0;
    fetch_valid = 1'b1;
    tick();
    chk("two_nt_predict_nt", 32'(pred_taken), 32'd0);
    chk("stats_branch_5", branch_count, 32'd5);
    chk("stats_mispredict_0", mispredict_count, 32'd0);
    fetch_valid = 1'b0;

    // Mispredict, actually taken.
    ex_drive(32'h200, 1'b0, 1'b1, 32'h400);
    tick();
    ex_valid = 1'b0;
    chk("mp_taken_valid", 32'(redirect_valid), 32'd1);
    chk("mp_taken_flush", 32'(flush), 32'd1);
    chk("mp_taken_pc", redirect_pc, 32'h400);
    chk("mp_taken_mcount", mispredict_count, 32'd1);
    chk("mp_taken_bcount", branch_count, 32'd6);
    tick();
    chk("mp_taken_pulse_end", 32'(redirect_valid), 32'd0);
    chk("mp_taken_flush_end", 32'(flush), 32'd0);

    // Back-to-back: not-taken with PC wrap, then taken, then a correct one.
    ex_drive(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h8);
    tick();
    chk("mp_wrap_valid", 32'(redirect_valid), 32'd1);
    chk("mp_wrap_pc", redirect_pc, 32'h0);
    ex_drive(32'h300, 1'b0, 1'b1, 32'h1234);
    tick();
    chk("mp_b2b_valid", 32'(redirect_valid), 32'd1);
    chk("mp_b2b_pc", redirect_pc, 32'h1234);
    ex_drive(32'h300, 1'b1, 1'b1, 32'h1234);
    tick();
    ex_valid = 1'b0;
    chk("correct_no_redirect", 32'(redirect_valid), 32'd0);
    chk("b2b_bcount", branch_count, 32'd9);
    chk("b2b_mcount", mispredict_count, 32'd3);

    // Same-cycle fetch and update on index 5: pre-update value is returned.
    fetch_valid = 1'b1; fetch_pc = 32'h14;
    ex_drive(32'h14, 1'b1, 1'b1, 32'h100);
    tick();
    ex_valid = 1'b0;
    chk("collide_pre_update", 32'(pred_taken), 32'd0);
    tick();
    chk("collide_after", 32'(pred_taken), 32'd1);
    fetch_valid = 1'b0;
    tick();

    // Asynchronous reset from RUN clears stats immediately.
    rst_n = 1'b0;
    #1;
    reset_vals("rst_run");
    tick();
    rst_n = 1'b1;

    // Reset 20 cycles into the sweep, with a redirect pulse pending.
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) ex_drive(32'h1000, 1'b0, 1'b1, 32'h2000);
      tick();
    end
    ex_valid = 1'b0;
    chk("pre_rst_redirect", 32'(redirect_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    reset_vals("rst_mid");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) begin fetch_valid = 1'b1; fetch_pc = 32'h14; end
      tick();
      if (i == 63) chk("reinit_busy_63", 32'(init_busy), 32'd1);
      if (i == 64) chk("reinit_busy_64", 32'(init_busy), 32'd0);
    end
    // Sweep reset index 5 back to WNT.
    tick();
    chk("reinit_idx5_wnt", 32'(pred_taken), 32'd0);
    chk("reinit_pred_valid", 32'(pred_valid), 32'd1);
    fetch_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
